// File: rtl/pcint1_ctrl.sv
// PCINT1 pin-change interrupt controller for Port C pins PC6..PC0.
// Synchronises pin inputs, detects masked edges and manages PCMSK1, PCICR.PCIE1 and PCIFR.PCIF1.
module pcint1_ctrl #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [5:0] PCIFR_IO_ADDR = 6'h1B,
    parameter logic [7:0] PCICR_ADDR    = 8'h68,
    parameter logic [7:0] PCMSK1_ADDR   = 8'h6C
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] IO_Addr,
    input  logic       iore,
    input  logic       iowe,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       out_en,
    input  logic [6:0] DIC_i,
    output logic [6:0] PCINT,
    output logic       PCIE1,
    output logic       pcint1_irq,
    input  logic       pcint1_irqack
);

    // state  | meaning
    // WARMUP | sync chain still filling after reset; edges are ignored
    // ARMED  | masked edges on the synchronised pins set PCIF1
    typedef enum logic {
        WARMUP = 1'b0,
        ARMED  = 1'b1
    } arm_state_t;

    localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES + 1);

    arm_state_t state, state_next;
    logic [2:0] count, count_next;

    logic [6:0] sync_chain [SYNC_STAGES];
    logic [6:0] sync;
    logic [6:0] prev;
    logic [6:0] chg;
    logic [6:0] pcmsk;
    logic       pcie;
    logic       pcif;

    logic pcifr_hit_wr;
    logic pcicr_hit_wr;
    logic pcmsk_hit_wr;
    logic flag_set;
    logic flag_clr;
    logic unused_bits;

    assign pcifr_hit_wr = iowe  && (IO_Addr == PCIFR_IO_ADDR);
    assign pcicr_hit_wr = ramwe && (ramadr == PCICR_ADDR);
    assign pcmsk_hit_wr = ramwe && (ramadr == PCMSK1_ADDR);
    assign unused_bits  = dbus_in[7];

    always_ff @(posedge cp2) begin
        if (ireset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= 7'h00;
            end
            prev <= 7'h00;
        end else begin
            sync_chain[0] <= DIC_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
            prev <= sync;
        end
    end

    assign sync = sync_chain[SYNC_STAGES-1];

    always_ff @(posedge cp2) begin
        if (ireset) begin
            state <= WARMUP;
            count <= 3'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            WARMUP: begin
                if (count == WARM_LAST) begin
                    state_next = ARMED;
                end else begin
                    count_next = count + 3'd1;
                end
            end
            ARMED: begin
                state_next = ARMED;
            end
            default: begin
                state_next = WARMUP;
                count_next = 3'd0;
            end
        endcase
    end

    // Edges seen while the chain fills are artefacts of reset, not real pin activity.
    assign chg      = (state == ARMED) ? ((sync ^ prev) & pcmsk) : 7'h00;
    assign flag_set = |chg;
    assign flag_clr = pcint1_irqack || (pcifr_hit_wr && dbus_in[1]);

    always_ff @(posedge cp2) begin
        if (ireset) begin
            pcmsk <= 7'h00;
            pcie  <= 1'b0;
            pcif  <= 1'b0;
        end else begin
            if (pcmsk_hit_wr) begin
                pcmsk <= dbus_in[6:0];
            end
            if (pcicr_hit_wr) begin
                pcie <= dbus_in[1];
            end
            // A new edge in the same cycle as a clear must not be lost.
            pcif <= flag_set || (pcif && !flag_clr);
        end
    end

    always_comb begin
        dbus_out = 8'h00;
        out_en   = 1'b0;
        if (iore && (IO_Addr == PCIFR_IO_ADDR)) begin
            dbus_out = {6'b0, pcif, 1'b0};
            out_en   = 1'b1;
        end else if (ramre && (ramadr == PCICR_ADDR)) begin
            dbus_out = {6'b0, pcie, 1'b0};
            out_en   = 1'b1;
        end else if (ramre && (ramadr == PCMSK1_ADDR)) begin
            dbus_out = {1'b0, pcmsk};
            out_en   = 1'b1;
        end
    end

    assign PCINT      = pcmsk;
    assign PCIE1      = pcie;
    assign pcint1_irq = pcif && pcie;

endmodule
